// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder memory-side responder.
// State encodings are shared with the processor's memory protocol view.
package mem_responder_pkg;

  localparam int unsigned MR_DATA_W      = 32;
  localparam int unsigned MR_ADDR_W      = 32;
  localparam int unsigned MR_DEPTH_LOG2  = 10;
  localparam int unsigned MR_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    MEM_RESP_IDLE = 2'd0,
    MEM_RESP_WAIT = 2'd1,
    MEM_RESP_DONE = 2'd2,
    MEM_RESP_HOLD = 2'd3
  } mem_resp_state_e;

  // Width of a counter that must hold wait_cycles-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// READ/WRITE level-strobe memory bus between the control unit (master) and
// the memory responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MR_DATA_W,
  parameter int unsigned ADDR_WIDTH = MR_ADDR_W
) ();

  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  err;

  modport master (
    output read, write, addr, data_in,
    input  data_out, ready, err
  );

  modport slave (
    input  read, write, addr, data_in,
    output data_out, ready, err
  );

endinterface

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous write, synchronous registered read.
// Contents are intentionally not reset.
module mem_resp_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one access per strobe assertion after WAIT_CYCLES wait
// states. Optional write protection below PROT_LIMIT via MEM_RESPONDER_PROTECT_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = MR_DATA_W,
  parameter int unsigned ADDR_WIDTH  = MR_ADDR_W,
  parameter int unsigned DEPTH_LOG2  = MR_DEPTH_LOG2,
  parameter int unsigned WAIT_CYCLES = MR_WAIT_CYCLES
`ifdef MEM_RESPONDER_PROTECT_EN
  ,
  parameter int unsigned PROT_LIMIT  = 0
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_responder_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

  mem_resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_wr_q, op_wr_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  rvld_q, rvld_d;
  logic                  go_done;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef MEM_RESPONDER_PROTECT_EN
  logic                  prot_q, prot_d;
`endif

  // Next-state, request capture and access strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    rvld_d  = rvld_q;
    go_done = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
`ifdef MEM_RESPONDER_PROTECT_EN
    prot_d  = prot_q;
`endif

    case (state_q)
      MEM_RESP_IDLE: begin
        if (bus.read ^ bus.write) begin
          addr_d  = bus.addr[DEPTH_LOG2-1:0];
          wdata_d = bus.data_in;
          op_wr_d = bus.write;
`ifdef MEM_RESPONDER_PROTECT_EN
          prot_d  = bus.write && (bus.addr < ADDR_WIDTH'(PROT_LIMIT));
`endif
          if (WAIT_CYCLES == 0) begin
            go_done = 1'b1;
            state_d = MEM_RESP_DONE;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = MEM_RESP_WAIT;
          end
        end else if (bus.read && bus.write) begin
          err_d   = 1'b1;
          state_d = MEM_RESP_HOLD;
        end
      end
      MEM_RESP_WAIT: begin
        if (cnt_q == '0) begin
          go_done = 1'b1;
          state_d = MEM_RESP_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEM_RESP_DONE: begin
        if (!bus.read && !bus.write) begin
          ready_d = 1'b0;
          state_d = MEM_RESP_IDLE;
        end
      end
      MEM_RESP_HOLD: begin
        if (!bus.read && !bus.write) begin
          state_d = MEM_RESP_IDLE;
        end
      end
      default: state_d = MEM_RESP_IDLE;
    endcase

    // The access itself happens on the edge that enters DONE, using the
    // captured request (live values when capture and completion coincide).
    if (go_done) begin
      ready_d = 1'b1;
      if (op_wr_d) begin
`ifdef MEM_RESPONDER_PROTECT_EN
        if (prot_d) begin
          err_d = 1'b1;
        end else begin
          mem_we = 1'b1;
        end
`else
        mem_we = 1'b1;
`endif
      end else begin
        mem_re = 1'b1;
        rvld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MEM_RESP_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
`ifdef MEM_RESPONDER_PROTECT_EN
      prot_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
`ifdef MEM_RESPONDER_PROTECT_EN
      prot_q  <= prot_d;
`endif
    end
  end

  mem_resp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_d),
    .wdata_i (wdata_d),
    .rdata_o (mem_rdata)
  );

  // The array read register is not reset, so DATA_OUT is forced to zero until
  // the first read completes after reset.
  assign bus.data_out = rvld_q ? mem_rdata : '0;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=2, DEPTH_LOG2=10); with
// MEM_RESPONDER_PROTECT_EN defined it also covers PROT_LIMIT=0x100.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  mem_responder #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .DEPTH_LOG2  (10),
    .WAIT_CYCLES (2)
`ifdef MEM_RESPONDER_PROTECT_EN
    ,
    .PROT_LIMIT  (32'h100)
`endif
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  // Under protection, shift the general tests above the protected region;
  // 0x400 aliases to the same word.
`ifdef MEM_RESPONDER_PROTECT_EN
  localparam logic [31:0] A_OFS = 32'h400;
`else
  localparam logic [31:0] A_OFS = 32'h0;
`endif

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] din;
    int          hold;
    int          exp_lat;
    int          exp_rdy;
    int          exp_err;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string nm, input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input int hold, input int lat, input int rdy,
                              input int err, input bit chk, input logic [31:0] exp);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.addr = a; v.din = d;
    v.hold = hold; v.exp_lat = lat; v.exp_rdy = rdy; v.exp_err = err;
    v.chk_data = chk; v.exp_data = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one strobe for v.hold edges, record READY/ERR behaviour, then drop it.
  task automatic run_vec(input vec_t v);
    int          lat;
    int          rdy;
    int          errc;
    logic [31:0] dout;
    lat = 0; rdy = 0; errc = 0;
    @(posedge clk); #1;
    bus_if.read    = v.rd;
    bus_if.write   = v.wr;
    bus_if.addr    = v.addr;
    bus_if.data_in = v.din;
    for (int c = 1; c <= v.hold; c++) begin
      @(posedge clk); #1;
      if (bus_if.ready === 1'b1) begin
        if (lat == 0) lat = c;
        rdy++;
      end
      if (bus_if.err === 1'b1) errc++;
    end
    dout = bus_if.data_out;
    bus_if.read  = 1'b0;
    bus_if.write = 1'b0;
    @(posedge clk); #1;
    if (bus_if.err === 1'b1) errc++;
    check({v.name, ".latency"},   32'(lat),  32'(v.exp_lat));
    check({v.name, ".ready_cyc"}, 32'(rdy),  32'(v.exp_rdy));
    check({v.name, ".err_cnt"},   32'(errc), 32'(v.exp_err));
    check({v.name, ".ready_off"}, 32'(bus_if.ready), 32'h0);
    if (v.chk_data) check({v.name, ".data_out"}, dout, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus_if.read    = 1'b0;
    bus_if.write   = 1'b0;
    bus_if.addr    = '0;
    bus_if.data_in = '0;

    //          name          rd wr addr            din           hold lat rdy err chk exp
    vecs.push_back(mk("wr10",      0, 1, 32'h10 + A_OFS,  32'hDEADBEEF, 5, 3, 3, 0, 1, 32'h0));
    vecs.push_back(mk("rd10",      1, 0, 32'h10 + A_OFS,  32'h0,        5, 3, 3, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk("rd10_held", 1, 0, 32'h10 + A_OFS,  32'h0,       10, 3, 8, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk("wr04",      0, 1, 32'h4 + A_OFS,   32'h12345678, 4, 3, 2, 0, 0, 32'h0));
    vecs.push_back(mk("both04",    1, 1, 32'h4 + A_OFS,   32'hFFFFFFFF, 4, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk("rd04",      1, 0, 32'h4 + A_OFS,   32'h0,        4, 3, 2, 0, 1, 32'h12345678));
    vecs.push_back(mk("wr400",     0, 1, 32'h400 + A_OFS, 32'h55,       4, 3, 2, 0, 0, 32'h0));
    vecs.push_back(mk("rd000",     1, 0, 32'h0 + A_OFS,   32'h0,        4, 3, 2, 0, 1, 32'h55));
    vecs.push_back(mk("wr20",      0, 1, 32'h20 + A_OFS,  32'h1,        4, 3, 2, 0, 0, 32'h0));

    repeat (2) @(posedge clk);
    #1;
    check("reset.ready",    32'(bus_if.ready), 32'h0);
    check("reset.err",      32'(bus_if.err),   32'h0);
    check("reset.data_out", bus_if.data_out,   32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during WAIT drops the pending write and clears outputs at once.
    @(posedge clk); #1;
    bus_if.write   = 1'b1;
    bus_if.addr    = 32'h20 + A_OFS;
    bus_if.data_in = 32'hAAAA5555;
    @(posedge clk); #1;
    check("rstwait.pre_ready", 32'(bus_if.ready), 32'h0);
    check("rstwait.pre_data",  bus_if.data_out,   32'h55);
    rst = 1'b1;
    #1;
    check("rstwait.ready", 32'(bus_if.ready), 32'h0);
    check("rstwait.err",   32'(bus_if.err),   32'h0);
    check("rstwait.data",  bus_if.data_out,   32'h0);
    bus_if.write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(mk("rd20_after_rst", 1, 0, 32'h20 + A_OFS, 32'h0, 4, 3, 2, 0, 1, 32'h1));

    // Strobe dropped during WAIT: the write still completes with latched values.
    @(posedge clk); #1;
    bus_if.write   = 1'b1;
    bus_if.addr    = 32'h30 + A_OFS;
    bus_if.data_in = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus_if.write   = 1'b0;
    bus_if.data_in = 32'h0;
    @(posedge clk); #1;
    check("drop.ready_e2", 32'(bus_if.ready), 32'h0);
    @(posedge clk); #1;
    check("drop.ready_e3", 32'(bus_if.ready), 32'h1);
    @(posedge clk); #1;
    check("drop.ready_e4", 32'(bus_if.ready), 32'h0);
    run_vec(mk("rd30", 1, 0, 32'h30 + A_OFS, 32'h0, 4, 3, 2, 0, 1, 32'hA5A5A5A5));

`ifdef MEM_RESPONDER_PROTECT_EN
    run_vec(mk("p_wr480", 0, 1, 32'h480, 32'hCAFE, 4, 3, 2, 0, 0, 32'h0));
    run_vec(mk("p_wr80",  0, 1, 32'h80,  32'h77,   4, 3, 2, 1, 0, 32'h0));
    run_vec(mk("p_rd80",  1, 0, 32'h80,  32'h0,    4, 3, 2, 0, 1, 32'hCAFE));
    run_vec(mk("p_wr100", 0, 1, 32'h100, 32'h99,   4, 3, 2, 0, 0, 32'h0));
    run_vec(mk("p_rd100", 1, 0, 32'h100, 32'h0,    4, 3, 2, 0, 1, 32'h99));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
